addsub_acc_pipe: RTL
====================

// Module: addsub_acc_pipe
// PURPOSE
//   Parametrised registered add/subtract unit with an optional running accumulator.
//   Produces carry/borrow, signed-overflow, zero and negative flags.
//   Has an optional unsigned saturation mode.
//   Uses valid/ready handshakes on input and output; one result register stage.
//   Serves as the datapath arithmetic core for the lab ALU and for counter/checksum blocks.
// PARAMETERS
//   WIDTH   8  operand, result and accumulator width in bits (>= 2)
//   SAT_EN  0  1: unsigned saturation of s_o/accumulator; 0: modulo 2^WIDTH wrap
// PORTS
//   clk_i        in   1      clock; all state updates on its rising edge
//   rst_ni       in   1      asynchronous, active-low reset
//   in_valid_i   in   1      operand/op presented
//   in_ready_o   out  1      unit can accept this cycle
//   a_i          in   WIDTH  operand A (ignored for accumulate ops)
//   b_i          in   WIDTH  operand B
//   op_i         in   2      00 A+B, 01 A-B, 10 ACC+B, 11 ACC-B
//   clr_i        in   1      synchronous accumulator clear (independent of handshake)
//   out_valid_o  out  1      result registers hold an unconsumed result
//   out_ready_i  in   1      downstream consumes result
//   s_o          out  WIDTH  result
//   c_o          out  1      add: carry-out; sub: borrow (1 when X < B unsigned)
//   v_o          out  1      signed two's-complement overflow of the raw result
//   z_o          out  1      s_o == 0 (after saturation)
//   n_o          out  1      s_o[WIDTH-1] (after saturation)
//   acc_o        out  WIDTH  current accumulator value
// BEHAVIOUR
//   Reset (rst_ni low, async):
//     - out_valid_o, s_o, c_o, v_o, z_o, n_o and acc_o all go to 0.
//     - Any pending result is discarded.
//     - in_ready_o = 1 as soon as reset is released.
//   Handshake:
//     - in_ready_o = !out_valid_o || out_ready_i (combinational).
//     - Accept = in_valid_i && in_ready_o.
//     - Accepted op appears on s_o/flags with out_valid_o=1 on the next edge (latency 1).
//     - Back-to-back throughput is one op per cycle while out_ready_i=1.
//     - While out_valid_o && !out_ready_i, all outputs hold stable and no input is accepted.
//     - Consume without accept: out_valid_o -> 0; s_o/flags keep their last value.
//   Arithmetic:
//     - X = a_i for op 0x, X = ACC for op 1x.
//     - raw = {1'b0,X} +/- {1'b0,b_i}, computed WIDTH+1 bits wide.
//     - c_o = raw[WIDTH].
//     - v_o, add: X and b have the same sign and the sign of raw[WIDTH-1:0] differs.
//     - v_o, sub: X and b differ in sign and the sign of raw[WIDTH-1:0] differs from X.
//     - SAT_EN=0: s_o = raw[WIDTH-1:0].
//     - SAT_EN=1: add with carry -> all ones; sub with borrow -> 0; c_o/v_o still report the raw event.
//   Accumulator:
//     - On accept of op 1x, ACC <= s_o value being registered.
//     - Op 0x leaves ACC unchanged.
//     - acc_o reflects ACC; it updates on the same edge as s_o.
//   clr_i:
//     - Alone: ACC <= 0 at the next edge.
//     - Same cycle as an accepted op 1x: clear applies first, so X=0 and ACC <= result of 0 +/- b_i.
//     - Does not affect out_valid_o or s_o.
//   Boundaries:
//     - Wrap: WIDTH=8, 0xFF+0x01 -> 0x00 with c=1, z=1.
//     - 0x00-0x01 -> 0xFF with c=1, n=1.
//     - Offers while stalled are not accepted; the producer must hold them.
// TESTING (WIDTH=8 unless noted)
//   1. Reset, then A=3,B=5,op=00 with out_ready=1 -> next cycle s=8, c=v=z=n=0, out_valid=1; in_ready stays 1.
//   2. A=0x7F,B=0x01,op=00 -> s=0x80, v=1, n=1, c=0; A=0x00,B=0x01,op=01 -> s=0xFF, c=1, v=0.
//   3. clr, then ACC+5, ACC+7, ACC-2 back-to-back -> acc_o 5, 12, 10 on successive cycles; clr with ACC-3 -> acc=0xFD, c=1.
//   4. Hold out_ready=0 for 3 cycles with a result pending -> in_ready=0, s_o stable, 2nd op accepted only on release, no loss or duplication.
//   5. SAT_EN=1: 0xF0+0x20 -> s=0xFF, c=1; 0x10-0x20 -> s=0x00, c=1, z=1; ACC saturates identically.
//   6. Assert rst_ni mid-stall with out_valid=1, acc=0x2A -> out_valid=0 and acc_o=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/addsub_acc_pipe_if.sv
// Handshake/operand bus for addsub_acc_pipe: input offer, registered result and flags.
interface addsub_acc_pipe_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic [1:0]       op_i;
    logic             clr_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] s_o;
    logic             c_o;
    logic             v_o;
    logic             z_o;
    logic             n_o;
    logic [WIDTH-1:0] acc_o;

    modport slave (
        input  in_valid_i, a_i, b_i, op_i, clr_i, out_ready_i,
        output in_ready_o, out_valid_o, s_o, c_o, v_o, z_o, n_o, acc_o
    );

    modport master (
        output in_valid_i, a_i, b_i, op_i, clr_i, out_ready_i,
        input  in_ready_o, out_valid_o, s_o, c_o, v_o, z_o, n_o, acc_o
    );
endinterface

// File: rtl/addsub_acc_pipe.sv
// Registered add/subtract core with running accumulator, NZCV-style flags,
// optional unsigned saturation and a single valid/ready result stage.
module addsub_acc_pipe #(
    parameter int unsigned WIDTH  = 8,
    parameter bit          SAT_EN = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    addsub_acc_pipe_if.slave bus
);
    localparam int unsigned RAW_W = WIDTH + 1;

    logic             in_ready_c;
    logic             accept_c;
    logic             sub_c;
    logic             carry_c;
    logic             ovf_c;
    logic [WIDTH-1:0] x_c;
    logic [WIDTH-1:0] res_c;
    logic [RAW_W-1:0] raw_c;

    logic             out_valid_q;
    logic [WIDTH-1:0] s_q;
    logic             c_q;
    logic             v_q;
    logic             z_q;
    logic             n_q;
    logic [WIDTH-1:0] acc_q;

    // Operand select, WIDTH+1 arithmetic, overflow and saturation
    always_comb begin
        in_ready_c = !out_valid_q || bus.out_ready_i;
        accept_c   = bus.in_valid_i && in_ready_c;
        sub_c      = bus.op_i[0];
        x_c        = bus.a_i;
        if (bus.op_i[1]) begin
            // a same-cycle clear takes effect before the accumulate op
            x_c = bus.clr_i ? '0 : acc_q;
        end
        raw_c   = sub_c ? (RAW_W'(x_c) - RAW_W'(bus.b_i))
                        : (RAW_W'(x_c) + RAW_W'(bus.b_i));
        carry_c = raw_c[WIDTH];
        if (sub_c) begin
            ovf_c = (x_c[WIDTH-1] != bus.b_i[WIDTH-1]) && (raw_c[WIDTH-1] != x_c[WIDTH-1]);
        end else begin
            ovf_c = (x_c[WIDTH-1] == bus.b_i[WIDTH-1]) && (raw_c[WIDTH-1] != x_c[WIDTH-1]);
        end
        res_c = raw_c[WIDTH-1:0];
        if (SAT_EN && carry_c) begin
            res_c = sub_c ? '0 : '1;
        end
    end

    // Result stage: load on accept, drop valid on consume-without-accept
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            s_q         <= '0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
        end else if (accept_c) begin
            out_valid_q <= 1'b1;
            s_q         <= res_c;
            c_q         <= carry_c;
            v_q         <= ovf_c;
            z_q         <= (res_c == '0);
            n_q         <= res_c[WIDTH-1];
        end else if (bus.out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    // Accumulator: clear is independent of the handshake
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else if (accept_c && bus.op_i[1]) begin
            acc_q <= res_c;
        end else if (bus.clr_i) begin
            acc_q <= '0;
        end
    end

    assign bus.in_ready_o  = in_ready_c;
    assign bus.out_valid_o = out_valid_q;
    assign bus.s_o         = s_q;
    assign bus.c_o         = c_q;
    assign bus.v_o         = v_q;
    assign bus.z_o         = z_q;
    assign bus.n_o         = n_q;
    assign bus.acc_o       = acc_q;
endmodule
